// File: rtl/controle_rolhas.sv
// Cork tray controller: 4-phase grant to the capping station, BCD tray level,
// 4-phase refill requests and CR/BZ flags. Define TOTAL_COUNT_EN to add total_rolhas.
module controle_rolhas #(
  parameter int unsigned REFILL_QTY      = 20,
  parameter int unsigned LOW_MARK        = 5,
  parameter int unsigned DISPENSE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pedido_rolha,
  output logic        rolha_ok,
  output logic        reabastecer_req,
  input  logic        reabastecer_ack,
  output logic [3:0]  unidades_bandeja,
  output logic [3:0]  dezenas_bandeja,
  output logic        CR,
  output logic        BZ
`ifdef TOTAL_COUNT_EN
  ,
  output logic [15:0] total_rolhas
`endif
);

  typedef enum logic [1:0] {IDLE, DISPENSE, RELEASE} state_t;

  localparam logic [3:0] INIT_TENS  = 4'(REFILL_QTY / 10);
  localparam logic [3:0] INIT_UNITS = 4'(REFILL_QTY % 10);
  localparam logic [3:0] CNT_LOAD   = 4'(DISPENSE_CYCLES - 1);
  localparam logic [7:0] REFILL_ADD = 8'(REFILL_QTY);
  localparam logic [7:0] LOW_LEVEL  = 8'(LOW_MARK);
  localparam logic [7:0] MAX_LEVEL  = 8'd99;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [7:0]  level, level_sum, level_next;
  logic [3:0]  tens_next, units_next;
  logic        req_next;
  logic        dec, add;

  assign level = 8'(dezenas_bandeja) * 8'd10 + 8'(unidades_bandeja);
  assign CR    = (level == LOW_LEVEL);
  assign BZ    = (level == '0);

  assign dec = (state == DISPENSE) && (cnt == '0);
  assign add = reabastecer_req && reabastecer_ack;

  // Dispense and refill can land on the same edge; merge them in binary
  // (8 bits so the sum cannot wrap before saturation), then re-split to BCD.
  always_comb begin
    level_sum  = level - 8'(dec) + (add ? REFILL_ADD : '0);
    level_next = (level_sum > MAX_LEVEL) ? MAX_LEVEL : level_sum;
    tens_next  = 4'(level_next / 8'd10);
    units_next = 4'(level_next % 8'd10);
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (pedido_rolha && (level != '0)) begin
          state_next = DISPENSE;
          cnt_next   = CNT_LOAD;
        end
      end
      DISPENSE: begin
        if (cnt == '0) state_next = RELEASE;
        else           cnt_next   = cnt - 4'd1;
      end
      RELEASE: begin
        if (!pedido_rolha) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_next = reabastecer_req;
    if (add)
      req_next = 1'b0;
    else if (!reabastecer_req && !reabastecer_ack && (level <= LOW_LEVEL))
      req_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      rolha_ok         <= 1'b0;
      reabastecer_req  <= 1'b0;
      dezenas_bandeja  <= INIT_TENS;
      unidades_bandeja <= INIT_UNITS;
    end else begin
      state            <= state_next;
      cnt              <= cnt_next;
      rolha_ok         <= (state_next == RELEASE);
      reabastecer_req  <= req_next;
      dezenas_bandeja  <= tens_next;
      unidades_bandeja <= units_next;
    end
  end

`ifdef TOTAL_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    total_rolhas <= '0;
    else if (dec) total_rolhas <= total_rolhas + 16'd1;
  end
`endif

endmodule
